// File: rtl/riscv_core_mul_div_pkg.sv
// Shared definitions for the mul/div control block and the iterative divider.
//   - op-code constants for the divide class (bit2=divide, bit1=remainder, bit0=unsigned)
//   - divider state encoding, also used by the control block
package riscv_core_mul_div_pkg;

   localparam logic [2:0] DIV  = 3'b100;
   localparam logic [2:0] DIVU = 3'b101;
   localparam logic [2:0] REM  = 3'b110;
   localparam logic [2:0] REMU = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/riscv_core_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and their *W forms.
// Ports:
//   i_divider_clk, i_divider_rstn    clock, async active-low reset
//   i_divider_start                  start request, sampled in IDLE only
//   i_divider_srcA / i_divider_srcB  dividend / divisor (valid in start cycle only)
//   i_divider_control                op code (bit2 divide class, bit1 remainder, bit0 unsigned)
//   i_divider_isword                 32-bit word operation
//   o_divider_result                 quotient or remainder, held until the next result
//   o_divider_busy                   high in CALC, FIX, DONE
//   o_divider_done                   one-cycle pulse in DONE
module riscv_core_divider
   import riscv_core_mul_div_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic            i_divider_clk,
   input  logic            i_divider_rstn,
   input  logic            i_divider_start,
   input  logic [XLEN-1:0] i_divider_srcA,
   input  logic [XLEN-1:0] i_divider_srcB,
   input  logic [2:0]      i_divider_control,
   input  logic            i_divider_isword,
   output logic [XLEN-1:0] o_divider_result,
   output logic            o_divider_busy,
   output logic            o_divider_done
);

   localparam int unsigned HALF  = XLEN / 2;
   localparam int unsigned W1    = XLEN + 1;
   localparam int unsigned CNT_W = $clog2(XLEN + 1);

   // Conditional two's-complement negation.
   function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + XLEN'(1)) : v;
   endfunction

   div_state_e       state_q, next_state;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN-1:0]  rem_q, quo_q, divisor_q, result_q;
   logic             op_rem_q, isword_q, q_sign_q, r_sign_q;
   logic             busy_q, done_q;

   logic             accept;
   logic             is_signed, sign_a, sign_b;
   logic [XLEN-1:0]  ext_a, ext_b, mag_a, mag_b, load_quo;
   logic [W1-1:0]    shifted, trial;
   logic [XLEN-1:0]  fix_quo, fix_rem, fix_sel, fix_res;

   // Next state, operand preparation, trial subtraction and result fix-up.
   always_comb begin
      next_state = state_q;
      accept     = 1'b0;
      ext_a      = i_divider_srcA;
      ext_b      = i_divider_srcB;
      is_signed  = ~i_divider_control[0];

      // Only divide-class ops are meaningful to this unit.
      if (state_q == IDLE && i_divider_start && i_divider_control[2]) begin
         accept = 1'b1;
      end

      // Word ops take the low half, sign- or zero-extended.
      if (i_divider_isword) begin
         ext_a = is_signed ? {{HALF{i_divider_srcA[HALF-1]}}, i_divider_srcA[HALF-1:0]}
                           : {{HALF{1'b0}}, i_divider_srcA[HALF-1:0]};
         ext_b = is_signed ? {{HALF{i_divider_srcB[HALF-1]}}, i_divider_srcB[HALF-1:0]}
                           : {{HALF{1'b0}}, i_divider_srcB[HALF-1:0]};
      end
      sign_a = is_signed & ext_a[XLEN-1];
      sign_b = is_signed & ext_b[XLEN-1];
      mag_a  = cond_neg(ext_a, sign_a);
      mag_b  = cond_neg(ext_b, sign_b);

      // Word dividends fit in HALF bits; park them in the top half so HALF steps consume them.
      load_quo = i_divider_isword ? {mag_a[HALF-1:0], {HALF{1'b0}}} : mag_a;

      // Shifted partial remainder needs one extra bit; a set MSB of the difference means negative.
      shifted = {rem_q, quo_q[XLEN-1]};
      trial   = shifted - {1'b0, divisor_q};

      // Divide-by-zero leaves the all-ones quotient unsigned.
      fix_quo = cond_neg(quo_q, q_sign_q & (divisor_q != '0));
      fix_rem = cond_neg(rem_q, r_sign_q);
      fix_sel = op_rem_q ? fix_rem : fix_quo;
      fix_res = isword_q ? {{HALF{fix_sel[HALF-1]}}, fix_sel[HALF-1:0]} : fix_sel;

      unique case (state_q)
         IDLE: if (accept) next_state = CALC;
         CALC: if (cnt_q == CNT_W'(1)) next_state = FIX;
         FIX:  next_state = DONE;
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge i_divider_clk or negedge i_divider_rstn) begin
      if (!i_divider_rstn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         divisor_q <= '0;
         result_q  <= '0;
         op_rem_q  <= 1'b0;
         isword_q  <= 1'b0;
         q_sign_q  <= 1'b0;
         r_sign_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q <= next_state;
         busy_q  <= (next_state != IDLE);
         done_q  <= (next_state == DONE);
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  op_rem_q  <= i_divider_control[1];
                  isword_q  <= i_divider_isword;
                  divisor_q <= mag_b;
                  quo_q     <= load_quo;
                  rem_q     <= '0;
                  q_sign_q  <= sign_a ^ sign_b;
                  r_sign_q  <= sign_a;
                  cnt_q     <= i_divider_isword ? CNT_W'(HALF) : CNT_W'(XLEN);
               end
            end
            CALC: begin
               rem_q <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
               quo_q <= {quo_q[XLEN-2:0], ~trial[XLEN]};
               cnt_q <= cnt_q - CNT_W'(1);
            end
            FIX: begin
               result_q <= fix_res;
            end
            default: ;
         endcase
      end
   end

   assign o_divider_result = result_q;
   assign o_divider_busy   = busy_q;
   assign o_divider_done   = done_q;

endmodule

// File: doc/riscv_core_divider.md
# riscv_core_divider

Iterative radix-2 integer divider that answers the divider start/done handshake issued by the core's mul/div control block. It accepts one operation per `start` pulse, computes the quotient or remainder of `DIV`, `DIVU`, `REM`, `REMU` and their 32-bit `*W` variants, then returns a one-cycle `done` with a held result. It sits beside the multiplier in the execute stage. The control block's output mux selects its result when no fast-path result applies.

## Interface
- `XLEN`, 64, datapath width; must be even; word ops use the low `XLEN/2` bits.
- `i_divider_clk`  in  1  clock
- `i_divider_rstn`  in  1  reset. One clock; reset is asynchronous and active-low.
- `i_divider_start`  in  1  start request; sampled only in IDLE
- `i_divider_srcA`  in  XLEN  dividend
- `i_divider_srcB`  in  XLEN  divisor
- `i_divider_control`  in  3  op code; [2]=1 for divide class, [1]=remainder, [0]=unsigned
- `i_divider_isword`  in  1  32-bit `*W` operation
- `o_divider_result`  out  XLEN  quotient or remainder; held until next accepted start
- `o_divider_busy`  out  1  high in CALC, FIX, DONE
- `o_divider_done`  out  1  high for exactly one cycle, in DONE

## Operation
- States and transitions:
  - IDLE → CALC on `start`.
  - CALC → CALC while the iteration counter is not zero.
  - CALC → FIX when the counter reaches zero.
  - FIX → DONE.
  - DONE → IDLE unconditionally.
- Launch (IDLE with `start`):
  - Latch the op code and `isword`.
  - Latch `|srcA|` and `|srcB|` as magnitudes. Magnitudes are taken only for signed ops.
  - Latch the quotient sign, `sA ^ sB`, and the remainder sign, `sA`.
  - For word ops the operands are the low `XLEN/2` bits. Signed word ops sign-extend those bits; unsigned word ops zero-extend them.
  - Load the counter with N: `XLEN` for normal ops, `XLEN/2` for word ops.
- CALC performs one restoring step per cycle:
  - `{rem, quo} <<= 1`
  - Compute the trial value `rem - divisor` as an (XLEN+1)-bit subtraction.
  - If it is non-negative, commit it and set the `quo` LSB to 1.
- FIX:
  - Negate the quotient if its sign is set and the divisor is non-zero.
  - Negate the remainder if its sign is set.
  - Select the quotient or the remainder using `control[1]`.
  - For word ops, sign-extend bit `XLEN/2-1` to `XLEN`.
  - Register the result in `o_divider_result`.
- Corner results fall out of the datapath and must match the RISC-V spec, even though the control block normally short-circuits them:
  - Divide by zero: quotient is all ones; remainder is the dividend.
  - Signed overflow (most-negative ÷ −1): quotient is the most-negative value; remainder is 0.
- `start` outside IDLE is ignored. The latched operands are not disturbed.

## Timing
- Reset values:
  - `o_divider_result` = 0
  - `o_divider_busy` = 0
  - `o_divider_done` = 0
  - State = IDLE; internal registers = 0.
- Cycle-level sequence, with `start` accepted in cycle 0:
  - CALC occupies cycles 1..N.
  - FIX occupies cycle N+1.
  - DONE occupies cycle N+2, with `done`=1 and the result valid.
  - IDLE resumes at cycle N+3.
- Latency is 66 cycles for 64-bit ops and 34 cycles for word ops.
- A new `start` is accepted at the earliest in cycle N+3.
- `done` and `busy` are decoded from the registered state only; there is no combinational path from inputs.
- Asynchronous reset mid-operation aborts the operation:
  - Return to IDLE.
  - Clear the result.
  - No `done` is produced.
- Operand inputs need to be valid only in the start cycle.

## Structure
- `riscv_core_mul_div_pkg` holds:
  - Op-code constants `DIV`=3'b100, `DIVU`=3'b101, `REM`=3'b110, `REMU`=3'b111.
  - The divider state enum `{IDLE, CALC, FIX, DONE}`, shared with the control block's state encoding.
- No sub-module. One always_ff holds the state and datapath registers. One always_comb holds next-state logic and the trial subtraction. A local function computes the conditional two's-complement negation.

## Test plan
- 64-bit tests:
  - `DIV` 100 / 7 → result 14, `done` in cycle 66, single-cycle pulse.
  - `REM` −7 / 2 → result 0xFFFF_FFFF_FFFF_FFFF (−1).
  - `REMU` 0xFFFF_FFFF_FFFF_FFFF / 0x10 → result 0xF.
  - `DIVU` x / 0 → result all ones.
  - `REM` 5 / 0 → result 5.
- Word test: `DIVW` srcA=0x0000_0000_8000_0000, srcB=0xFFFF_FFFF_FFFF_FFFF → result 0xFFFF_FFFF_8000_0000, `done` in cycle 34.
- Busy test:
  - Pulse `start` again in cycle 10 with different operands → ignored.
  - The original result is returned and no second `done` occurs.
- Reset test:
  - Deassert `rstn` in cycle 20 → `busy`/`done`/result are 0 immediately.
  - A following `DIV` 9 / 3 → 3.
